// File: rtl/mips32_program_loader.sv
// mips32_program_loader: streams instruction words into imem, then runs the core for a set cycle budget.
module mips32_program_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_cycles,
  output logic              cpu_run,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              done,
  output logic              overflow
);
  typedef enum logic [1:0] {LOAD, ARMED, RUN, DONE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_budget;
  logic              w_ptr_max;
  assign in_ready  = r_state == LOAD;
  assign w_ptr_max = &r_ptr;
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state     <= LOAD;
      r_ptr       <= '0;
      r_budget    <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      cpu_run     <= 1'b0;
      cycle_count <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        LOAD: if (in_valid) begin
          imem_we    <= 1'b1;
          imem_addr  <= r_ptr;
          imem_wdata <= in_data;
          r_ptr      <= r_ptr + 1'b1;
          if (in_last || w_ptr_max) r_state <= ARMED;
          if (!in_last && w_ptr_max) overflow <= 1'b1;
        end
        ARMED, DONE: if (start) begin
          r_budget    <= run_cycles;
          cycle_count <= '0;
          done        <= run_cycles == '0;
          cpu_run     <= run_cycles != '0;
          r_state     <= run_cycles == '0 ? DONE : RUN;
        end
        RUN: begin
          cycle_count <= cycle_count + 1'b1;
          if (cycle_count == r_budget - 1'b1) begin
            cpu_run <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_mips32_program_loader.sv
// tb_mips32_program_loader: directed and randomized checks of the loader against a transaction-level model.
module tb_mips32_program_loader;
  logic        clk1 = 0, rst = 1, in_valid = 0, in_last = 0, start = 0;
  logic [31:0] in_data = 0;
  logic [7:0]  run_cycles = 0;
  logic        in_ready, imem_we, cpu_run, done, overflow;
  logic [7:0]  imem_addr, cycle_count;
  logic [31:0] imem_wdata;
  logic        in_ready2, imem_we2, cpu_run2, done2, overflow2;
  logic [1:0]  imem_addr2;
  logic [7:0]  cycle_count2;
  logic [31:0] imem_wdata2;
  int checks = 0, errors = 0;
  bit          m_loading, m_ovf;
  int          m_ptr;
  logic [31:0] m_addr, m_data;
  logic [31:0] prog [4] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};

  mips32_program_loader #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .start(start), .run_cycles(run_cycles), .cpu_run(cpu_run), .cycle_count(cycle_count),
    .done(done), .overflow(overflow));

  mips32_program_loader #(.ADDR_W(2), .CNT_W(8)) dut2 (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready2), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .start(start), .run_cycles(run_cycles), .cpu_run(cpu_run2), .cycle_count(cycle_count2),
    .done(done2), .overflow(overflow2));

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset;
    rst = 1; in_valid = 0; in_last = 0; start = 0;
    step; step;
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", in_ready, 1);
    rst = 0;
    m_loading = 1; m_ovf = 0; m_ptr = 0; m_addr = 0; m_data = 0;
  endtask

  // One cycle of load traffic; the word is written one cycle later at the next free address.
  task automatic send(input logic v, input logic [31:0] d, input logic l);
    bit acc;
    acc = v && m_loading;
    chk("in_ready", in_ready, m_loading);
    in_valid = v; in_data = d; in_last = l;
    step;
    in_valid = 0; in_last = 0; in_data = $urandom;
    if (acc) begin
      m_addr = m_ptr;
      m_data = d;
      m_ptr = (m_ptr + 1) % 256;
      if (l || m_addr == 255) m_loading = 0;
      if (!l && m_addr == 255) m_ovf = 1;
    end
    chk("imem_we", imem_we, acc);
    chk("imem_addr", imem_addr, m_addr);
    chk("imem_wdata", imem_wdata, m_data);
    chk("overflow", overflow, m_ovf);
  endtask

  // Issue start with budget b; core must run exactly b cycles, ignoring start/run_cycles noise.
  task automatic run(input int b);
    run_cycles = b[7:0]; start = 1;
    step;
    start = 0; run_cycles = $urandom;
    for (int i = 0; i < b; i++) begin
      chk("run_cpu_run", cpu_run, 1);
      chk("run_count", cycle_count, i);
      chk("run_done", done, 0);
      start = $urandom_range(0, 1); run_cycles = $urandom;
      step;
    end
    start = 0;
    chk("end_cpu_run", cpu_run, 0);
    chk("end_done", done, 1);
    chk("end_count", cycle_count, b);
    chk("end_ready", in_ready, 0);
  endtask

  initial begin
    do_reset;
    for (int i = 0; i < 4; i++) begin
      send(1, prog[i], i == 3);
      send(0, 32'hDEADBEEF, 0);
    end
    send(1, 32'h12345678, 1);
    run(0);
    run(3);

    do_reset;
    for (int i = 0; i < 4; i++) send(1, prog[i], i == 3);
    send(1, 32'hCAFEF00D, 0);
    run(18);

    for (int r = 0; r < 3; r++) begin
      int n;
      do_reset;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        int idle;
        idle = $urandom_range(0, 2);
        for (int k = 0; k < idle; k++) send(0, $urandom, $urandom_range(0, 1));
        send(1, $urandom, i == n - 1);
      end
      run($urandom_range(1, 40));
      run($urandom_range(0, 5));
    end

    do_reset;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] d;
      d = $urandom;
      in_valid = 1; in_data = d; in_last = 0;
      step;
      chk("ovf_we", imem_we2, 1);
      chk("ovf_addr", imem_addr2, k);
      chk("ovf_wdata", imem_wdata2, d);
    end
    chk("ovf_flag", overflow2, 1);
    chk("ovf_ready", in_ready2, 0);
    step;
    in_valid = 0;
    chk("ovf_5th_we", imem_we2, 0);
    chk("ovf_5th_addr", imem_addr2, 3);

    do_reset;
    for (int i = 0; i < 4; i++) send(1, prog[i], i == 3);
    run_cycles = 18; start = 1;
    step;
    start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_cpu_run", cpu_run, 1);
      step;
    end
    rst = 1;
    step;
    chk("midrst_cpu_run", cpu_run, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", cycle_count, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_ready", in_ready, 1);
    rst = 0;
    m_loading = 1; m_ovf = 0; m_ptr = 0; m_addr = 0; m_data = 0;
    for (int i = 0; i < 4; i++) send(1, prog[3 - i], i == 3);
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout observed=running expected=finished");
  end
endmodule
